uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of byte-stream requesters (range 2..8).
REQ-002 The block SHALL have parameter MAX_LEN, default 64, giving the maximum payload bytes per packet before a forced release (range 1..255).
REQ-003 The block SHALL have parameter HDR_BASE, default 8'hF0, giving the header byte base; the header is HDR_BASE OR requester index.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high: clk_i  input  1  rising-edge clock; rst_i  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have req_valid_i  input  NREQ  per-requester byte valid.
REQ-006 The block SHALL have req_data_i  input  NREQ x 8  per-requester payload byte.
REQ-007 The block SHALL have req_last_i  input  NREQ  marks the final byte of the packet.
REQ-008 The block SHALL have req_ready_o  output  NREQ  per-requester byte accepted.
REQ-009 The block SHALL have tx_full_i  input  1  UART TX FIFO full.
REQ-010 The block SHALL have wr_uart_o  output  1  UART TX FIFO write strobe.
REQ-011 The block SHALL have w_data_o  output  8  UART TX FIFO write data.
REQ-012 The block SHALL have grant_o  output  NREQ  one-hot current owner; zero when idle.
REQ-013 The block SHALL have busy_o  output  1  set in the HDR and DATA states.
REQ-014 The block SHALL have forced_o  output  1  one-cycle pulse when a packet is cut at MAX_LEN.

Function
REQ-015 The FSM SHALL have three states, IDLE, HDR and DATA, held in a registered state, owner index and byte counter.
REQ-016 In IDLE, when any req_valid_i is set, the FSM SHALL register the round-robin winner (search starts at last_owner+1, wrapping) and enter HDR on the next cycle; otherwise it SHALL stay in IDLE.
REQ-017 In HDR, when tx_full_i=0, the block SHALL assert wr_uart_o combinationally, drive w_data_o=HDR_BASE|owner, and enter DATA; when tx_full_i=1 it SHALL hold in HDR.
REQ-018 In DATA, req_ready_o[owner] SHALL equal ~tx_full_i, and all other ready bits SHALL be 0.
REQ-019 In DATA, wr_uart_o SHALL equal req_valid_i[owner] & ~tx_full_i, and w_data_o SHALL equal req_data_i[owner].
REQ-020 A byte SHALL transfer only on a cycle with valid & ready; each transfer increments the byte counter (8-bit, cleared on entry to HDR).
REQ-021 A transfer with req_last_i[owner]=1 SHALL return the FSM to IDLE and load last_owner=owner.
REQ-022 A transfer that brings the counter to MAX_LEN without last SHALL return the FSM to IDLE, load last_owner=owner and pulse forced_o for one cycle.
REQ-023 Valid deasserting mid-packet SHALL hold the FSM in DATA indefinitely, with no timeout.
REQ-024 The minimum turnaround SHALL be 1 idle cycle between packets (last transfer -> IDLE -> HDR).
REQ-025 In IDLE, wr_uart_o, req_ready_o and grant_o SHALL be 0, and w_data_o SHALL be 8'h00.
REQ-026 Requests that change in IDLE SHALL affect only the winner registered on that cycle; the owner SHALL be stable through HDR and DATA.

Reset
REQ-027 While rst_i is asserted, the block SHALL force state=IDLE, last_owner=NREQ-1 (so requester 0 wins first), counter=0, and forced_o=0.
REQ-028 While rst_i is asserted, wr_uart_o, req_ready_o, grant_o, busy_o and w_data_o SHALL all be 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet with no further write; after release, arbitration SHALL restart from requester 0.

Structure
REQ-030 The state enum (IDLE/HDR/DATA) and default HDR_BASE SHALL reside in shared package uart_pkg.
REQ-031 The round-robin priority pick SHALL be sub-module rr_arbiter (inputs: request vector, last index; output: winner index and any-request flag), which is purely combinational and parameterised by NREQ.
REQ-032 The block SHALL connect directly to the uart wr_uart_i, w_data_i and tx_full_o ports; no extra buffering is permitted.

Verification
REQ-033 Single packet: req0 sends 3 bytes 11,22,33 (last on 33), tx_full=0 -> UART writes F0,11,22,33 on consecutive cycles; grant_o=0001 during the packet, then 0.
REQ-034 Round-robin: req0 and req2 hold continuous 1-byte packets -> headers alternate F0,F2,F0,F2; req1 and req3 never get ready.
REQ-035 Backpressure: tx_full_i=1 for 5 cycles in HDR, then during byte 2 -> no write while full, no byte lost or duplicated, and the byte order is preserved.
REQ-036 Forced release: MAX_LEN=4, req1 streams 6 bytes without last, req2 pending -> F1 + 4 bytes, forced_o pulses once, then F2 is sent before req1 resumes.
REQ-037 Reset mid-packet: rst_i asserted after byte 1 of req3 -> outputs 0 the same cycle; after release, with req0 and req3 both pending, req0 is granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and the
// default header byte base.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hF0;

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Round-robin priority pick. The search starts one past the last owner and
// wraps, so the most recent owner always ends up with the lowest priority.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [IDXW-1:0] winner,
    output logic            any
);

    logic [IDXW-1:0] cand;
    logic            found;

    assign any = |req;

    // Walk the requesters in priority order and keep the first one that is asking.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDXW'((int'(last) + i) % NREQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Multiplexes several byte-stream requesters onto one UART TX FIFO. Each
// packet goes out as a header byte (HDR_BASE | owner) followed by payload.
// A packet ends on the requester's last flag or is cut at MAX_LEN bytes.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int          NREQ     = 4,
    parameter int          MAX_LEN  = 64,
    parameter logic [7:0]  HDR_BASE = HDR_BASE_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ-1:0][7:0] req_data_i,
    input  logic [NREQ-1:0]      req_last_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic                 tx_full_i,
    output logic                 wr_uart_o,
    output logic [7:0]           w_data_o,
    output logic [NREQ-1:0]      grant_o,
    output logic                 busy_o,
    output logic                 forced_o
);

    localparam int              IDXW       = $clog2(NREQ);
    localparam logic [7:0]      MAX_CNT    = 8'(MAX_LEN);
    localparam logic [IDXW-1:0] LAST_RESET = IDXW'(NREQ - 1);

    state_t          state;
    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] last_owner;
    logic [IDXW-1:0] winner;
    logic            any_req;
    logic [7:0]      byte_cnt;
    logic [7:0]      cnt_next;
    logic            fire;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req    (req_valid_i),
        .last   (last_owner),
        .winner (winner),
        .any    (any_req)
    );

    assign fire     = (state == DATA) && req_valid_i[owner] && !tx_full_i;
    assign cnt_next = byte_cnt + 8'd1;

    // Packet FSM: latch the winner in IDLE, send the header, then stream payload
    // until last or the length cap, remembering the owner for the next search.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_RESET;
            byte_cnt   <= '0;
            forced_o   <= 1'b0;
        end else begin
            forced_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= winner;
                        byte_cnt <= '0;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (!tx_full_i) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (fire) begin
                        byte_cnt <= cnt_next;
                        if (req_last_i[owner]) begin
                            state      <= IDLE;
                            last_owner <= owner;
                        end else if (cnt_next == MAX_CNT) begin
                            state      <= IDLE;
                            last_owner <= owner;
                            forced_o   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO-side outputs follow the state directly so a byte moves the same
    // cycle the FIFO has room; everything is quiet in IDLE.
    always_comb begin
        wr_uart_o   = 1'b0;
        w_data_o    = 8'h00;
        req_ready_o = '0;
        grant_o     = '0;
        busy_o      = 1'b0;
        case (state)
            HDR: begin
                busy_o         = 1'b1;
                grant_o[owner] = 1'b1;
                wr_uart_o      = !tx_full_i;
                w_data_o       = HDR_BASE | 8'(owner);
            end
            DATA: begin
                busy_o             = 1'b1;
                grant_o[owner]     = 1'b1;
                req_ready_o[owner] = !tx_full_i;
                wr_uart_o          = fire;
                w_data_o           = req_data_i[owner];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-fed requesters on the input side and a
// scoreboard of expected FIFO writes on the output side.
module tb_uart_tx_arb;

    localparam int NREQ    = 4;
    localparam int MAX_LEN = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } srcItem_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] grant;
    } expItem_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0][7:0] req_data_i;
    logic [NREQ-1:0]      req_last_i;
    logic [NREQ-1:0]      req_ready_o;
    logic                 tx_full_i;
    logic                 wr_uart_o;
    logic [7:0]           w_data_o;
    logic [NREQ-1:0]      grant_o;
    logic                 busy_o;
    logic                 forced_o;

    srcItem_t srcQ[NREQ][$];
    expItem_t expQ[$];
    int       writeCycles[$];
    int       assertCount = 0;
    int       failCount   = 0;
    int       forcedCount = 0;
    int       cycle       = 0;
    logic [NREQ-1:0] readySeen = '0;

    uart_tx_arb #(
        .NREQ    (NREQ),
        .MAX_LEN (MAX_LEN),
        .HDR_BASE(8'hF0)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_full_i   (tx_full_i),
        .wr_uart_o   (wr_uart_o),
        .w_data_o    (w_data_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .forced_o    (forced_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
        srcItem_t item;
        item.data = data;
        item.last = last;
        srcQ[req].push_back(item);
    endtask

    task automatic expectByte(input logic [7:0] data, input logic [3:0] grant);
        expItem_t item;
        item.data  = data;
        item.grant = grant;
        expQ.push_back(item);
    endtask

    task automatic doReset();
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        @(posedge clk_i); #2;
        rst_i = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk_i); #2;
            n++;
        end
        checkOutput(tag, 32'(expQ.size()), 32'd0);
    endtask

    // Requester models: present the head of each queue and pop it once the
    // DUT has taken it on a clock edge.
    initial begin : driver
        logic [NREQ-1:0] fire;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        forever begin
            @(posedge clk_i);
            fire = req_valid_i & req_ready_o;
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fire[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
                if (srcQ[i].size() > 0) begin
                    req_valid_i[i] = 1'b1;
                    req_data_i[i]  = srcQ[i][0].data;
                    req_last_i[i]  = srcQ[i][0].last;
                end else begin
                    req_valid_i[i] = 1'b0;
                    req_data_i[i]  = 8'h00;
                    req_last_i[i]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: every FIFO write is matched against the scoreboard.
    initial begin : monitor
        expItem_t e;
        forever begin
            @(negedge clk_i);
            cycle++;
            if (!rst_i) begin
                readySeen = readySeen | req_ready_o;
                if (tx_full_i) checkOutput("no_write_while_full", 32'(wr_uart_o), 32'd0);
                if (forced_o) forcedCount++;
                if (wr_uart_o) begin
                    writeCycles.push_back(cycle);
                    checkOutput("unexpected_write", 32'(expQ.size() != 0), 32'd1);
                    if (expQ.size() != 0) begin
                        e = expQ.pop_front();
                        checkOutput("w_data", 32'(w_data_o), 32'(e.data));
                        checkOutput("grant", 32'(grant_o), 32'(e.grant));
                        checkOutput("ready_outside_owner", 32'(req_ready_o & ~e.grant), 32'd0);
                    end
                end
            end
        end
    end

    // Directed sequence of scenarios.
    initial begin : stimulus
        int n;
        int forcedBase;
        int span;
        rst_i     = 1'b1;
        tx_full_i = 1'b0;

        repeat (2) @(posedge clk_i);
        #2;
        checkOutput("rst_wr", 32'(wr_uart_o), 32'd0);
        checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
        checkOutput("rst_grant", 32'(grant_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_wdata", 32'(w_data_o), 32'd0);
        checkOutput("rst_forced", 32'(forced_o), 32'd0);
        rst_i = 1'b0;

        $display("[TB] single packet");
        writeCycles.delete();
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h22, 1'b0);
        applyStimulus(0, 8'h33, 1'b1);
        expectByte(8'hF0, 4'b0001);
        expectByte(8'h11, 4'b0001);
        expectByte(8'h22, 4'b0001);
        expectByte(8'h33, 4'b0001);
        waitDrain("single_drain", 40);
        checkOutput("single_write_count", 32'(writeCycles.size()), 32'd4);
        span = (writeCycles.size() > 0) ? writeCycles[writeCycles.size()-1] - writeCycles[0] : -1;
        checkOutput("single_consecutive", 32'(span), 32'd3);
        checkOutput("idle_grant", 32'(grant_o), 32'd0);
        checkOutput("idle_busy", 32'(busy_o), 32'd0);
        checkOutput("idle_wdata", 32'(w_data_o), 32'd0);
        checkOutput("idle_ready", 32'(req_ready_o), 32'd0);

        $display("[TB] round robin");
        doReset();
        readySeen = '0;
        applyStimulus(0, 8'h01, 1'b1);
        applyStimulus(0, 8'h02, 1'b1);
        applyStimulus(2, 8'h21, 1'b1);
        applyStimulus(2, 8'h22, 1'b1);
        expectByte(8'hF0, 4'b0001);
        expectByte(8'h01, 4'b0001);
        expectByte(8'hF2, 4'b0100);
        expectByte(8'h21, 4'b0100);
        expectByte(8'hF0, 4'b0001);
        expectByte(8'h02, 4'b0001);
        expectByte(8'hF2, 4'b0100);
        expectByte(8'h22, 4'b0100);
        waitDrain("rr_drain", 60);
        checkOutput("rr_ready_1_3", 32'(readySeen & 4'b1010), 32'd0);
        checkOutput("rr_no_forced", 32'(forcedCount), 32'd0);

        $display("[TB] backpressure");
        doReset();
        tx_full_i = 1'b1;
        applyStimulus(0, 8'hA1, 1'b0);
        applyStimulus(0, 8'hA2, 1'b0);
        applyStimulus(0, 8'hA3, 1'b1);
        expectByte(8'hF0, 4'b0001);
        expectByte(8'hA1, 4'b0001);
        expectByte(8'hA2, 4'b0001);
        expectByte(8'hA3, 4'b0001);
        n = 0;
        while (!busy_o && n < 10) begin
            @(posedge clk_i); #2;
            n++;
        end
        checkOutput("bp_hdr_busy", 32'(busy_o), 32'd1);
        checkOutput("bp_hdr_grant", 32'(grant_o), 32'd1);
        checkOutput("bp_hdr_nowrite", 32'(wr_uart_o), 32'd0);
        repeat (5) @(posedge clk_i);
        #2;
        tx_full_i = 1'b0;
        n = 0;
        while (expQ.size() > 2 && n < 20) begin
            @(posedge clk_i); #2;
            n++;
        end
        checkOutput("bp_after_byte1", 32'(expQ.size()), 32'd2);
        tx_full_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #2;
        tx_full_i = 1'b0;
        waitDrain("bp_drain", 40);

        $display("[TB] forced release");
        doReset();
        forcedBase = forcedCount;
        for (int i = 0; i < 6; i++) applyStimulus(1, 8'(8'h10 + i), 1'b0);
        applyStimulus(2, 8'h20, 1'b1);
        expectByte(8'hF1, 4'b0010);
        for (int i = 0; i < 4; i++) expectByte(8'(8'h10 + i), 4'b0010);
        expectByte(8'hF2, 4'b0100);
        expectByte(8'h20, 4'b0100);
        expectByte(8'hF1, 4'b0010);
        expectByte(8'h14, 4'b0010);
        expectByte(8'h15, 4'b0010);
        waitDrain("forced_drain", 60);
        repeat (3) @(posedge clk_i);
        #2;
        checkOutput("forced_once", 32'(forcedCount - forcedBase), 32'd1);
        checkOutput("stall_busy", 32'(busy_o), 32'd1);
        checkOutput("stall_grant", 32'(grant_o), 32'b0010);
        checkOutput("stall_nowrite", 32'(wr_uart_o), 32'd0);

        $display("[TB] reset mid-packet");
        doReset();
        applyStimulus(3, 8'h30, 1'b0);
        applyStimulus(3, 8'h31, 1'b0);
        applyStimulus(3, 8'h32, 1'b1);
        expectByte(8'hF3, 4'b1000);
        expectByte(8'h30, 4'b1000);
        waitDrain("mid_first_byte", 30);
        rst_i = 1'b1;
        #1;
        checkOutput("mid_rst_wr", 32'(wr_uart_o), 32'd0);
        checkOutput("mid_rst_ready", 32'(req_ready_o), 32'd0);
        checkOutput("mid_rst_grant", 32'(grant_o), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("mid_rst_wdata", 32'(w_data_o), 32'd0);
        applyStimulus(0, 8'h40, 1'b0);
        applyStimulus(0, 8'h41, 1'b1);
        expectByte(8'hF0, 4'b0001);
        expectByte(8'h40, 4'b0001);
        expectByte(8'h41, 4'b0001);
        expectByte(8'hF3, 4'b1000);
        expectByte(8'h31, 4'b1000);
        expectByte(8'h32, 4'b1000);
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        waitDrain("mid_restart_drain", 60);
        repeat (2) @(posedge clk_i);
        #2;
        checkOutput("mid_final_idle", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
